// File: rtl/pending_encoder8_3_if.sv
// Request/issue bundle for pending_encoder8_3.
// master = encoder side, slave = requester/consumer side.
interface pending_encoder8_3_if;
    logic [7:0] req;
    logic       ready;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pend;
    logic       ovf;

    modport master (
        input  req,
        input  ready,
        output valid,
        output code,
        output pend,
        output ovf
    );

    modport slave (
        output req,
        output ready,
        input  valid,
        input  code,
        input  pend,
        input  ovf
    );
endinterface

// File: rtl/pending_encoder8_3.sv
// Latching 8-to-3 priority encoder with a valid/ready issue slot.
// Define PENDING_ENC_RR_EN for round-robin pick instead of highest-index.
module pending_encoder8_3 (
    input  logic                  clk,
    input  logic                  rst,
    pending_encoder8_3_if.master  bus
);

    logic [7:0] pend_q;
    logic       valid_q;
    logic [2:0] code_q;
    logic       ovf_q;

    logic       free;
    logic       found;
    logic [2:0] pick;
    logic [2:0] idx;
    logic [7:0] clear_mask;
    logic [7:0] pend_next;
    logic       ovf_next;

`ifdef PENDING_ENC_RR_EN
    logic [2:0] rp_q;
`endif

    assign free = ~valid_q | bus.ready;

    // Pick only looks at the registered pend; same-edge req is not eligible.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        idx   = 3'd0;
`ifdef PENDING_ENC_RR_EN
        for (int i = 0; i < 8; i++) begin
            idx = rp_q - 3'(i);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
`else
        for (int i = 7; i >= 0; i--) begin
            idx = 3'(i);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
`endif
    end

    always_comb begin
        clear_mask = 8'h00;
        if (free && found)
            clear_mask = 8'h01 << pick;
        pend_next = (pend_q & ~clear_mask) | bus.req;
        ovf_next  = |(bus.req & pend_q & ~clear_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 8'h00;
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q <= pend_next;
            ovf_q  <= ovf_next;
            if (free) begin
                valid_q <= found;
                if (found)
                    code_q <= pick;
            end
        end
    end

`ifdef PENDING_ENC_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rp_q <= 3'd7;
        else if (free && found)
            rp_q <= pick - 3'd1;
    end
`endif

    assign bus.valid = valid_q;
    assign bus.code  = code_q;
    assign bus.pend  = pend_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_pending_encoder8_3.sv
// Bench for pending_encoder8_3: directed scenarios plus random traffic
// checked against a bit-array model of the pending set and issue slot.
module tb_pending_encoder8_3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pending_encoder8_3_if bus ();

    pending_encoder8_3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    bit m_pend [8];
    bit m_valid;
    int m_code;
    bit m_ovf;
    int m_rp;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
        m_valid = 0;
        m_code  = 0;
        m_ovf   = 0;
        m_rp    = 7;
    endtask

    // One clock: drive inputs, predict, clock, compare everything.
    task automatic step(input logic [7:0] r, input logic rd);
        bit free;
        int sel;
        bit n_pend [8];
        bit n_valid;
        int n_code;
        bit n_ovf;
        bus.req   = r;
        bus.ready = rd;
        free    = !m_valid || rd;
        sel     = -1;
        n_valid = m_valid;
        n_code  = m_code;
        if (free) begin
`ifdef PENDING_ENC_RR_EN
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_rp - k + 8) % 8;
                if (sel < 0 && m_pend[c]) sel = c;
            end
`else
            for (int c = 7; c >= 0; c--)
                if (sel < 0 && m_pend[c]) sel = c;
`endif
            n_valid = (sel >= 0);
            if (sel >= 0) begin
                n_code = sel;
                m_rp   = (sel + 7) % 8;
            end
        end
        n_ovf = 0;
        for (int i = 0; i < 8; i++) begin
            if (r[i] && m_pend[i] && i != sel) n_ovf = 1;
            n_pend[i] = (m_pend[i] && i != sel) || r[i];
        end
        @(posedge clk);
        #1;
        m_pend  = n_pend;
        m_valid = n_valid;
        m_code  = n_code;
        m_ovf   = n_ovf;
        check("valid", 32'(bus.valid), 32'(m_valid));
        if (m_valid) check("code", 32'(bus.code), 32'(m_code));
        check("pend", 32'(bus.pend), 32'(m_pend_vec()));
        check("ovf", 32'(bus.ovf), 32'(m_ovf));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        bus.req   = 8'h00;
        bus.ready = 1'b0;
        m_reset();
        #12;
        check("rst_pend", 32'(bus.pend), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_code", 32'(bus.code), 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single request: 2 cycles to valid
        step(8'h08, 1'b1);
        check("single_pend", 32'(bus.pend), 32'h08);
        check("single_v0", 32'(bus.valid), 32'h0);
        step(8'h00, 1'b1);
        check("single_v1", 32'(bus.valid), 32'h1);
        check("single_code", 32'(bus.code), 32'h3);
        check("single_pend0", 32'(bus.pend), 32'h00);
        step(8'h00, 1'b1);
        check("single_idle", 32'(bus.valid), 32'h0);

        // Priority and backpressure
        step(8'h81, 1'b0);
        step(8'h00, 1'b0);
        check("prio_code7", 32'(bus.code), 32'h7);
        check("prio_pend", 32'(bus.pend), 32'h01);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b0);
            check("hold_code", 32'(bus.code), 32'h7);
            check("hold_valid", 32'(bus.valid), 32'h1);
        end
        step(8'h00, 1'b1);
        check("prio_code0", 32'(bus.code), 32'h0);
        check("prio_valid0", 32'(bus.valid), 32'h1);
        step(8'h00, 1'b1);
        check("prio_drain", 32'(bus.valid), 32'h0);

        // Continuous 7/0 requests: alternation or starvation per build
        for (int i = 0; i < 8; i++) step(8'h81, 1'b1);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1);

        // Overflow
        step(8'h80, 1'b0);
        step(8'h04, 1'b0);
        check("ovf_pend", 32'(bus.pend), 32'h04);
        step(8'h04, 1'b0);
        check("ovf_hit", 32'(bus.ovf), 32'h1);
        check("ovf_pend_keep", 32'(bus.pend), 32'h04);
        step(8'h00, 1'b0);
        check("ovf_pulse", 32'(bus.ovf), 32'h0);
        step(8'h80, 1'b0);
        check("slot_req_ovf", 32'(bus.ovf), 32'h0);
        check("slot_req_pend", 32'(bus.pend), 32'h84);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1);

        // Same-edge clear and set
        step(8'h10, 1'b1);
        check("same_pend", 32'(bus.pend), 32'h10);
        step(8'h10, 1'b1);
        check("same_code", 32'(bus.code), 32'h4);
        check("same_pend_kept", 32'(bus.pend), 32'h10);
        check("same_ovf", 32'(bus.ovf), 32'h0);
        step(8'h00, 1'b1);
        check("same_again", 32'(bus.code), 32'h4);
        check("same_valid", 32'(bus.valid), 32'h1);
        step(8'h00, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step(r, 1'($urandom_range(0, 3) != 0 ? 1 : 0));
        end
        for (int i = 0; i < 10; i++) step(8'h00, 1'b1);

        // Asynchronous reset mid-stream
        step(8'h80, 1'b0);
        step(8'hA5, 1'b0);
        check("pre_rst_pend", 32'(bus.pend), 32'hA5);
        check("pre_rst_valid", 32'(bus.valid), 32'h1);
        bus.req = 8'h00;
        #2 rst = 1'b1;
        #1;
        m_reset();
        check("arst_pend", 32'(bus.pend), 32'h0);
        check("arst_valid", 32'(bus.valid), 32'h0);
        check("arst_code", 32'(bus.code), 32'h0);
        check("arst_ovf", 32'(bus.ovf), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b1);
            check("post_rst_idle", 32'(bus.valid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
